// File: rtl/rob_commit_queue_pkg.sv
// Shared ROB types and constants for the reorder buffer and its bus neighbours.
//   rob_entry_t      : one reorder-buffer slot (busy, done, rd, value, mispredict, target)
//   rob_to_regfile_t : payload of the ROB -> regfile commit bus
//   rob_to_all_t     : ROB broadcast to the rest of the core (flush)
package rob_entry_structs;

    localparam int unsigned ROB_DEPTH = 32;
    localparam int unsigned ROB_IDXW  = $clog2(ROB_DEPTH);
    localparam int unsigned ROB_XLEN  = 32;
    localparam int unsigned ROB_RDW   = 5;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic [ROB_RDW-1:0]  rd;
        logic [ROB_XLEN-1:0] value;
        logic                mispredict;
        logic [ROB_XLEN-1:0] target;
    } rob_entry_t;

    typedef struct packed {
        logic                valid;
        logic [ROB_RDW-1:0]  regfile_idx;
        logic [ROB_XLEN-1:0] value;
        logic [ROB_IDXW-1:0] rob_idx;
    } rob_to_regfile_t;

    typedef struct packed {
        logic flush_all;
    } rob_to_all_t;

endpackage

// File: rtl/rob_commit_queue.sv
// Circular reorder buffer: in-order allocate, out-of-order writeback capture,
// in-order single commit per cycle, full flush when a mispredicted branch commits.
// Optional macro ROB_WB_BYPASS_EN: a writeback hitting the busy head commits in
// the same cycle (0-cycle writeback-to-commit latency). Undefined: 1-cycle minimum.
// Ports:
//   clk, rst (async, active low)
//   alloc_valid/alloc_rd -> alloc_ready/alloc_rob_idx     : dispatch allocation
//   wb_valid/wb_rob_idx/wb_value/wb_mispredict/wb_target  : writeback bus
//   commit_valid/commit_rd/commit_value/commit_rob_idx    : regfile commit bus (combinational from head)
//   flush_all/flush_target                                : redirect broadcast
//   empty                                                 : no entries held
module rob_commit_queue
    import rob_entry_structs::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    input  logic [ROB_RDW-1:0]         alloc_rd,
    output logic                       alloc_ready,
    output logic [$clog2(DEPTH)-1:0]   alloc_rob_idx,
    input  logic                       wb_valid,
    input  logic [$clog2(DEPTH)-1:0]   wb_rob_idx,
    input  logic [ROB_XLEN-1:0]        wb_value,
    input  logic                       wb_mispredict,
    input  logic [ROB_XLEN-1:0]        wb_target,
    output logic                       commit_valid,
    output logic [ROB_RDW-1:0]         commit_rd,
    output logic [ROB_XLEN-1:0]        commit_value,
    output logic [$clog2(DEPTH)-1:0]   commit_rob_idx,
    output logic                       flush_all,
    output logic [ROB_XLEN-1:0]        flush_target,
    output logic                       empty
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CNTW = IDXW + 1;

    rob_entry_t            entry_q [DEPTH];
    logic [IDXW-1:0]       head_q;
    logic [IDXW-1:0]       tail_q;
    logic [CNTW-1:0]       count_q;

    rob_entry_t            head_e;
    logic                  alloc_fire;
    logic                  commit_fire;
    logic                  wb_hit_head;
    logic                  head_mispredict;
    logic [ROB_XLEN-1:0]   head_target;

    // Allocation, commit and flush decode from registered state (plus optional bypass)
    always_comb begin
        head_e          = entry_q[head_q];
        alloc_ready     = (count_q < CNTW'(DEPTH));
        alloc_fire      = alloc_valid & alloc_ready;
        alloc_rob_idx   = tail_q;
        empty           = (count_q == '0);
`ifdef ROB_WB_BYPASS_EN
        wb_hit_head     = wb_valid & (wb_rob_idx == head_q) & head_e.busy;
`else
        wb_hit_head     = 1'b0;
`endif
        commit_valid    = head_e.busy & (head_e.done | wb_hit_head);
        commit_rd       = head_e.rd;
        commit_value    = wb_hit_head ? wb_value      : head_e.value;
        head_mispredict = wb_hit_head ? wb_mispredict : head_e.mispredict;
        head_target     = wb_hit_head ? wb_target     : head_e.target;
        commit_rob_idx  = head_q;
        commit_fire     = commit_valid;
        flush_all       = commit_valid & head_mispredict;
        flush_target    = head_target;
    end

    // Pointers and occupancy; flush rewinds everything to the reset position
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_all) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire)  tail_q <= tail_q + IDXW'(1);
            if (commit_fire) head_q <= head_q + IDXW'(1);
            count_q <= count_q + CNTW'(alloc_fire) - CNTW'(commit_fire);
        end
    end

    // Entry storage; commit clear is last so it wins over a same-slot writeback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i].busy <= 1'b0;
                entry_q[i].done <= 1'b0;
            end
        end else begin
            if (wb_valid && entry_q[wb_rob_idx].busy) begin
                entry_q[wb_rob_idx].done       <= 1'b1;
                entry_q[wb_rob_idx].value      <= wb_value;
                entry_q[wb_rob_idx].mispredict <= wb_mispredict;
                entry_q[wb_rob_idx].target     <= wb_target;
            end
            if (alloc_fire) begin
                entry_q[tail_q].busy       <= 1'b1;
                entry_q[tail_q].done       <= 1'b0;
                entry_q[tail_q].rd         <= alloc_rd;
                entry_q[tail_q].mispredict <= 1'b0;
            end
            if (commit_fire) begin
                entry_q[head_q].busy <= 1'b0;
                entry_q[head_q].done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue; follows ROB_WB_BYPASS_EN if defined.
module tb_rob_commit_queue;

`ifdef ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [4:0]  alloc_rob_idx;
    logic        wb_valid;
    logic [4:0]  wb_rob_idx;
    logic [31:0] wb_value;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [4:0]  commit_rob_idx;
    logic        flush_all;
    logic [31:0] flush_target;
    logic        empty;

    int total = 0;
    int bad   = 0;

    rob_commit_queue dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_ready    (alloc_ready),
        .alloc_rob_idx  (alloc_rob_idx),
        .wb_valid       (wb_valid),
        .wb_rob_idx     (wb_rob_idx),
        .wb_value       (wb_value),
        .wb_mispredict  (wb_mispredict),
        .wb_target      (wb_target),
        .commit_valid   (commit_valid),
        .commit_rd      (commit_rd),
        .commit_value   (commit_value),
        .commit_rob_idx (commit_rob_idx),
        .flush_all      (flush_all),
        .flush_target   (flush_target),
        .empty          (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid   = 1'b0;
        alloc_rd      = '0;
        wb_valid      = 1'b0;
        wb_rob_idx    = '0;
        wb_value      = '0;
        wb_mispredict = 1'b0;
        wb_target     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic alloc_n(input int n, input logic [4:0] rd0);
        for (int i = 0; i < n; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = rd0 + 5'(i);
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] idx, input logic [31:0] val,
                      input logic mp, input logic [31:0] tgt);
        wb_valid      = 1'b1;
        wb_rob_idx    = idx;
        wb_value      = val;
        wb_mispredict = mp;
        wb_target     = tgt;
    endtask

    initial begin
        // 1: reset values
        do_reset();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_alloc_idx", alloc_rob_idx, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush_all, 0);
        chk("rst_commit_value", commit_value, 0);

        // 2: out-of-order writeback, in-order commit
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(5 + i);
            #1;
            chk("t2_alloc_idx", alloc_rob_idx, 64'(i));
            tick();
        end
        alloc_valid = 1'b0;
        wb(5'd1, 32'h22, 1'b0, 32'h0);
        #1;
        chk("t2_no_commit_idx1_first", commit_valid, 0);
        tick();
        wb(5'd0, 32'h11, 1'b0, 32'h0);
        #1;
        chk("t2_wb0_cycle_valid", commit_valid, BYP);
`ifdef ROB_WB_BYPASS_EN
        chk("t2_byp_value", commit_value, 32'h11);
        chk("t2_byp_rd", commit_rd, 5);
`endif
        tick();
        idle_inputs();
        #1;
`ifndef ROB_WB_BYPASS_EN
        chk("t2_c0_valid", commit_valid, 1);
        chk("t2_c0_idx", commit_rob_idx, 0);
        chk("t2_c0_rd", commit_rd, 5);
        chk("t2_c0_value", commit_value, 32'h11);
        tick();
`endif
        chk("t2_c1_valid", commit_valid, 1);
        chk("t2_c1_idx", commit_rob_idx, 1);
        chk("t2_c1_rd", commit_rd, 6);
        chk("t2_c1_value", commit_value, 32'h22);
        tick();
        chk("t2_c2_wait", commit_valid, 0);
        chk("t2_c2_idx", commit_rob_idx, 2);
        chk("t2_not_empty", empty, 0);
        tick();
        chk("t2_c2_still_wait", commit_valid, 0);

        // 3: fill, full stall, wrap
        do_reset();
        for (int i = 0; i < 32; i++) begin
            alloc_valid = 1'b1;
            alloc_rd    = 5'(i);
            #1;
            if (alloc_rob_idx !== 5'(i)) chk("t3_fill_idx", alloc_rob_idx, 64'(i));
            tick();
        end
        alloc_rd = 5'd9;
        #1;
        chk("t3_full_ready", alloc_ready, 0);
        chk("t3_full_idx", alloc_rob_idx, 0);
        tick();
        chk("t3_33rd_ignored", alloc_ready, 0);
        chk("t3_head_idx", commit_rob_idx, 0);
        wb(5'd0, 32'h55, 1'b0, 32'h0);
        #1;
        chk("t3_wb_cycle_valid", commit_valid, BYP);
        chk("t3_wb_cycle_ready", alloc_ready, 0);
`ifdef ROB_WB_BYPASS_EN
        chk("t3_byp_value", commit_value, 32'h55);
`else
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t3_commit_valid", commit_valid, 1);
        chk("t3_commit_value", commit_value, 32'h55);
        chk("t3_commit_no_alloc", alloc_ready, 0);
`endif
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t3_wrap_ready", alloc_ready, 1);
        chk("t3_wrap_idx", alloc_rob_idx, 0);
        chk("t3_head_adv", commit_rob_idx, 1);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("t3_refull_ready", alloc_ready, 0);
        chk("t3_refull_idx", alloc_rob_idx, 1);

        // 4: mispredict commit flushes
        do_reset();
        alloc_n(4, 5'd1);
        wb(5'd1, 32'hA1, 1'b1, 32'h100);
        #1;
        chk("t4_no_flush_early", flush_all, 0);
        tick();
        wb(5'd0, 32'hA0, 1'b0, 32'h0);
        #1;
        chk("t4_wb0_cycle_valid", commit_valid, BYP);
        tick();
        idle_inputs();
`ifndef ROB_WB_BYPASS_EN
        #1;
        chk("t4_c0_valid", commit_valid, 1);
        chk("t4_c0_value", commit_value, 32'hA0);
        chk("t4_c0_flush", flush_all, 0);
        tick();
`endif
        alloc_valid = 1'b1;
        alloc_rd    = 5'd7;
        wb(5'd2, 32'h77, 1'b0, 32'h0);
        #1;
        chk("t4_flush_valid", commit_valid, 1);
        chk("t4_flush_idx", commit_rob_idx, 1);
        chk("t4_flush_rd", commit_rd, 2);
        chk("t4_flush_value", commit_value, 32'hA1);
        chk("t4_flush_all", flush_all, 1);
        chk("t4_flush_target", flush_target, 32'h100);
        tick();
        idle_inputs();
        #1;
        chk("t4_post_empty", empty, 1);
        chk("t4_post_idx", alloc_rob_idx, 0);
        chk("t4_post_flush_pulse", flush_all, 0);
        chk("t4_post_commit", commit_valid, 0);
        wb(5'd2, 32'hEE, 1'b0, 32'h0);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t4_late_wb_valid", commit_valid, 0);
        chk("t4_late_wb_empty", empty, 1);

        // 5: stray writeback, then asynchronous reset mid-stream
        do_reset();
        wb(5'd9, 32'h99, 1'b0, 32'h0);
        #1;
        chk("t5_stray_now", commit_valid, 0);
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stray_later", commit_valid, 0);
            tick();
        end
        chk("t5_stray_empty", empty, 1);
        alloc_n(5, 5'd3);
        #1;
        chk("t5_pending_idx", alloc_rob_idx, 5);
        chk("t5_pending_empty", empty, 0);
        rst = 1'b0;
        #1;
        chk("t5_arst_idx", alloc_rob_idx, 0);
        chk("t5_arst_empty", empty, 1);
        chk("t5_arst_ready", alloc_ready, 1);
        chk("t5_arst_commit", commit_valid, 0);
        chk("t5_arst_rd", commit_rd, 0);

        // 6: writeback-to-commit latency
        do_reset();
        alloc_n(1, 5'd4);
        wb(5'd0, 32'hAB, 1'b0, 32'h0);
        #1;
        chk("t6_same_cycle", commit_valid, BYP);
`ifdef ROB_WB_BYPASS_EN
        chk("t6_byp_value", commit_value, 32'hAB);
`endif
        tick();
        wb_valid = 1'b0;
        #1;
        chk("t6_next_cycle", commit_valid, !BYP);
`ifndef ROB_WB_BYPASS_EN
        chk("t6_next_value", commit_value, 32'hAB);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
